// File: rtl/rpn_stack.sv
// Calculator operand stack: top in a register, lower entries in a sync-read RAM.
// A pop needing RAM data takes one extra cycle; a one-deep latch holds a command issued then.
module rpn_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int SIZE_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 replace,
  input  logic [WIDTH-1:0]     in_num,
  output logic [WIDTH-1:0]     top,
  output logic [SIZE_BITS-1:0] size,
  output logic                 error,
  output logic                 out_vld
);

  localparam int AW = SIZE_BITS - 1;

  typedef enum logic {READY, POP_WAIT} state_t;
  typedef enum logic [1:0] {
    OP_NONE, OP_PUSH, OP_POP, OP_REP
  } op_t;

  state_t           state;
  op_t              lat_op;
  logic             lat_vld;
  logic [WIDTH-1:0] lat_num;

  logic [WIDTH-1:0] mem [DEPTH-1];
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;

  op_t              in_op;
  op_t              exec_op;
  logic [WIDTH-1:0] exec_num;
  logic             any_in;
  logic             multi;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_rep;
  logic             do_pop1;
  logic             do_popram;
  logic             ram_we;
  logic             err_set;

  always_comb begin
    any_in = push | pop | replace;
    multi  = (push & pop) | (push & replace) | (pop & replace);
    in_op  = OP_NONE;
    if (push)         in_op = OP_PUSH;
    else if (pop)     in_op = OP_POP;
    else if (replace) in_op = OP_REP;

    exec_op  = OP_NONE;
    exec_num = in_num;
    if (state == READY) begin
      if (lat_vld) begin
        exec_op  = lat_op;
        exec_num = lat_num;
      end else if (!multi) begin
        exec_op  = in_op;
      end
    end

    full      = (size == SIZE_BITS'(DEPTH));
    empty     = (size == '0);
    do_push   = (exec_op == OP_PUSH) && !full;
    do_rep    = (exec_op == OP_REP) && !empty;
    do_pop1   = (exec_op == OP_POP) && (size == SIZE_BITS'(1));
    do_popram = (exec_op == OP_POP) && (size > SIZE_BITS'(1));
    ram_we    = do_push && !empty;
    wr_addr   = AW'(size - SIZE_BITS'(1));
    rd_addr   = AW'(size - SIZE_BITS'(2));

    // Latched command has priority; anything new beside it is dropped.
    err_set = multi
            | ((state == READY) && lat_vld && any_in)
            | ((exec_op == OP_PUSH) && full)
            | (((exec_op == OP_POP) || (exec_op == OP_REP)) && empty);
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= top;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= READY;
      top     <= '0;
      size    <= '0;
      error   <= 1'b0;
      out_vld <= 1'b1;
      lat_vld <= 1'b0;
      lat_op  <= OP_NONE;
      lat_num <= '0;
    end else begin
      if (err_set) error <= 1'b1;
      unique case (state)
        READY: begin
          lat_vld <= 1'b0;
          if (do_push) begin
            top  <= exec_num;
            size <= size + SIZE_BITS'(1);
          end
          if (do_rep) top <= exec_num;
          if (do_pop1) begin
            top  <= '0;
            size <= '0;
          end
          if (do_popram) begin
            size    <= size - SIZE_BITS'(1);
            out_vld <= 1'b0;
            state   <= POP_WAIT;
          end
        end
        POP_WAIT: begin
          top     <= rd_data;
          out_vld <= 1'b1;
          state   <= READY;
          if (any_in && !multi) begin
            lat_vld <= 1'b1;
            lat_op  <= in_op;
            lat_num <= in_num;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack: vector table plus hand-written
// sequences for fill, command latch and reset during a pop.
module tb_rpn_stack;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int SB = 4;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic          replace;
  logic [W-1:0]  in_num;
  logic [W-1:0]  top;
  logic [SB-1:0] size;
  logic          error;
  logic          out_vld;

  int tests;
  int fails;

  rpn_stack #(.WIDTH(W), .DEPTH(D), .SIZE_BITS(SB)) dut (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .in_num  (in_num),
    .top     (top),
    .size    (size),
    .error   (error),
    .out_vld (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         p;
    logic         o;
    logic         r;
    logic [W-1:0] n;
    logic [W-1:0] t;
    int           s;
    logic         e;
    logic         v;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int t, input int s,
                         input int e, input int v);
    chk({nm, ".top"}, int'(top), t);
    chk({nm, ".size"}, int'(size), s);
    chk({nm, ".err"}, int'(error), e);
    chk({nm, ".vld"}, int'(out_vld), v);
  endtask

  task automatic cyc(input logic p, input logic o, input logic r,
                     input logic [W-1:0] n);
    push = p; pop = o; replace = r; in_num = n;
    @(posedge clk);
    #1;
    push = 0; pop = 0; replace = 0; in_num = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    push = 0; pop = 0; replace = 0; in_num = '0; reset = 1'b1;

    vecs[0]  = '{1, 0, 0, 16'h0005, 16'h0005, 1, 0, 1};
    vecs[1]  = '{1, 0, 0, 16'h0007, 16'h0007, 2, 0, 1};
    vecs[2]  = '{1, 0, 0, 16'h0009, 16'h0009, 3, 0, 1};
    vecs[3]  = '{0, 1, 0, 16'h0000, 16'h0009, 2, 0, 0};
    vecs[4]  = '{0, 0, 0, 16'h0000, 16'h0007, 2, 0, 1};
    vecs[5]  = '{0, 0, 1, 16'h00AB, 16'h00AB, 2, 0, 1};
    vecs[6]  = '{0, 1, 0, 16'h0000, 16'h00AB, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 16'h0000, 16'h0005, 1, 0, 1};
    vecs[8]  = '{0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1};
    vecs[9]  = '{1, 0, 0, 16'h0012, 16'h0012, 1, 0, 1};
    vecs[10] = '{0, 1, 0, 16'h0000, 16'h0000, 0, 0, 1};
    vecs[11] = '{1, 0, 0, 16'h3412, 16'h3412, 1, 0, 1};
    vecs[12] = '{1, 1, 0, 16'h0077, 16'h3412, 1, 1, 1};
    vecs[13] = '{0, 0, 1, 16'h0066, 16'h0066, 1, 1, 1};

    @(posedge clk);
    #1;
    do_reset();
    chk_all("reset", 0, 0, 0, 1);

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].p, vecs[i].o, vecs[i].r, vecs[i].n);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].t), vecs[i].s,
              int'(vecs[i].e), int'(vecs[i].v));
    end

    // Empty pop and full push
    do_reset();
    cyc(0, 1, 0, '0);
    chk_all("pop_empty", 0, 0, 1, 1);
    do_reset();
    for (int i = 1; i <= D; i++) cyc(1, 0, 0, W'(i * 16 + 3));
    chk_all("full", D * 16 + 3, D, 0, 1);
    cyc(1, 0, 0, 16'h0999);
    chk_all("push_full", D * 16 + 3, D, 1, 1);
    for (int i = D - 1; i >= 1; i--) begin
      cyc(0, 1, 0, '0);
      chk($sformatf("drain%0d.vld", i), int'(out_vld), 0);
      cyc(0, 0, 0, '0);
      chk($sformatf("drain%0d.top", i), int'(top), i * 16 + 3);
      chk($sformatf("drain%0d.size", i), int'(size), i);
    end

    // Push issued during the pop wait is latched and runs next
    do_reset();
    cyc(1, 0, 0, 16'h0005);
    cyc(1, 0, 0, 16'h0007);
    cyc(1, 0, 0, 16'h0009);
    cyc(0, 1, 0, '0);
    cyc(1, 0, 0, 16'h0044);
    chk_all("lat_wait", 16'h0007, 2, 0, 1);
    cyc(0, 0, 0, '0);
    chk_all("lat_exec", 16'h0044, 3, 0, 1);
    cyc(0, 1, 0, '0);
    cyc(0, 0, 0, '0);
    chk_all("lat_pop", 16'h0007, 2, 0, 1);

    // New command while latch is full is dropped with error
    cyc(0, 1, 0, '0);
    cyc(1, 0, 0, 16'h0055);
    cyc(1, 0, 0, 16'h0066);
    chk_all("lat_full", 16'h0055, 2, 1, 1);
    cyc(0, 0, 0, '0);
    chk_all("lat_full2", 16'h0055, 2, 1, 1);

    // Reset while a latched push is pending
    do_reset();
    cyc(1, 0, 0, 16'h0005);
    cyc(1, 0, 0, 16'h0007);
    cyc(1, 0, 1, 16'h0001);
    cyc(0, 1, 0, '0);
    push = 1; in_num = 16'h0044; reset = 1'b1;
    @(posedge clk);
    #1;
    push = 0; in_num = '0; reset = 1'b0;
    chk_all("rst_wait", 0, 0, 0, 1);
    cyc(0, 1, 0, '0);
    cyc(1, 0, 0, 16'h0033);
    chk_all("rst_lat", 16'h0033, 1, 1, 1);
    do_reset();
    cyc(0, 0, 0, '0);
    chk_all("rst_lat2", 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
